mmio_bus_arbiter: RTL and testbench
===================================

// Module: mmio_bus_arbiter
// PURPOSE
//  Shares the 8-bit MMIO register bus (cs/rd/wr/addr/wdata/rdata) of the fuzzy-controller
//  register map between N_REQ requesters (host bridge, config loader, auto-tuner).
//  Round-robin grant, one transaction at a time. Generates the bus timing and returns read data.
//  Holds off writes to the coefficient region while the core reports busy.
// PARAMETERS
//  N_REQ     2      number of requester ports (>=1)
//  READ_LAT  1      slave read latency in cycles; rdata valid READ_LAT cycles after cs&rd first sampled
//  PROT_LO   8'h10  lowest protected address (T/dT thresholds, gains, ALPHA, K_DT, D_MAX)
//  PROT_HI   8'h42  highest protected address
// PORTS
//  clk         in   1          clock
//  rst         in   1          synchronous reset, active-high
//  req_valid   in   N_REQ      per-port request pending
//  req_we      in   N_REQ      1=write, 0=read
//  req_addr    in   N_REQ*8    packed per-port address, port i at [8i+:8]
//  req_wdata   in   N_REQ*8    packed per-port write data
//  req_ready   out  N_REQ      one-hot accept strobe; request fields are latched when valid&ready
//  rsp_valid   out  N_REQ      one-cycle completion pulse to the granted port
//  rsp_rdata   out  8          read data, valid with rsp_valid (0 for writes)
//  core_busy   in   1          status_busy from the controller core
//  cs,rd,wr    out  1 each     MMIO bus strobes
//  addr,wdata  out  8 each     MMIO bus address and write data
//  rdata       in   8          MMIO read data
//  bus_busy    out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, rr pointer=0, latched request cleared.
//  Eligibility, evaluated in IDLE: valid[i] && !(we[i] && PROT_LO<=addr[i]<=PROT_HI && core_busy).
//  Grant, in IDLE: first eligible port scanning ptr, ptr+1, ... mod N_REQ.
//   - req_ready[g] is driven combinationally in that cycle.
//   - addr/wdata/we/g are registered at the edge.
//   - ptr <= (g+1) mod N_REQ.
//  Ineligible ports do not block others. A held-off write waits; its req_ready stays 0.
//  FSM states: IDLE -> XFER -> RESP -> IDLE.
//   XFER write: 1 cycle; cs=1, wr=1, addr and wdata driven.
//   XFER read: READ_LAT+1 cycles; cs=1, rd=1, addr driven, wdata=0.
//     rdata is captured at the edge that ends the last XFER cycle.
//   RESP: 1 cycle; cs/rd/wr/addr/wdata=0; rsp_valid[g]=1; rsp_rdata = captured data (0 for writes).
//   Back in IDLE a new grant may occur in the first cycle.
//  Latency, grant cycle t:
//   - write: bus active in t+1, rsp in t+2, 3-cycle throughput.
//   - read: bus active in t+1..t+1+READ_LAT, rsp in t+2+READ_LAT.
//  Outside XFER, cs/rd/wr/addr/wdata=0. rd and wr are never high together. cs is low for >=1 cycle between transactions.
//  core_busy is sampled only in IDLE. A change during XFER does not abort a granted write.
//  rsp_rdata holds its last value until the next RESP. rsp_valid is exactly one cycle.
//  Requester deasserting req_valid before ready: no transaction. After ready, changes are ignored.
//  Reset in any state: next edge returns to IDLE with bus strobes low; no rsp pulse for the aborted transfer; ptr=0.
//  N_REQ=1: ptr is constant 0, arbitration is trivial, timing is unchanged.
// TESTING
//  1 Port0 write 0x10<=0xA1, then port0 read 0x10 -> write bus cycle t+1; rsp_rdata=0xA1 at t+2+READ_LAT of the read grant.
//  2 Both ports valid continuously, reads of 0x30/0x38 -> grants alternate 0,1,0,1; each rsp_valid goes only to its owner.
//  3 core_busy=1, port0 writes 0x40, port1 reads 0x41 -> port1 served. Port0 ready stays 0 until core_busy=0, then its write issues.
//  4 core_busy=1, write to 0x01 (outside PROT range) -> issued immediately, wr pulse 1 cycle.
//  5 rst=1 in a read XFER cycle -> next cycle cs=rd=0, no rsp_valid, bus_busy=0; after release port0 wins first.
//  6 Assertions over all runs: !(rd&&wr); cs==(rd||wr); $onehot0(rsp_valid|req_ready); READ_LAT=2 rerun gives rsp 1 cycle later.

Source files
------------

// File: rtl/mmio_bus_arbiter_if.sv
// Requester-side handshake plus MMIO register bus of the fuzzy-controller arbiter.
// master = requesters/bus slave environment, slave = the arbiter itself.
interface mmio_bus_arbiter_if #(parameter int N_REQ = 2);
    logic [N_REQ-1:0]      req_valid;
    logic [N_REQ-1:0]      req_we;
    logic [N_REQ-1:0][7:0] req_addr;
    logic [N_REQ-1:0][7:0] req_wdata;
    logic [N_REQ-1:0]      req_ready;
    logic [N_REQ-1:0]      rsp_valid;
    logic [7:0]            rsp_rdata;
    logic                  core_busy;
    logic                  cs;
    logic                  rd;
    logic                  wr;
    logic [7:0]            addr;
    logic [7:0]            wdata;
    logic [7:0]            rdata;
    logic                  bus_busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, core_busy, rdata,
        input  req_ready, rsp_valid, rsp_rdata, cs, rd, wr, addr, wdata, bus_busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, core_busy, rdata,
        output req_ready, rsp_valid, rsp_rdata, cs, rd, wr, addr, wdata, bus_busy
    );
endinterface

// File: rtl/mmio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit MMIO register bus between N_REQ requesters,
// holding off coefficient-region writes while the core is busy.

// Per-port eligibility: a write into the protected window waits out core_busy.
module mmio_arb_elig #(
    parameter logic [7:0] PROT_LO = 8'h10,
    parameter logic [7:0] PROT_HI = 8'h42
) (
    input  logic       valid,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic       core_busy,
    output logic       elig
);
    logic prot;
    assign prot = (addr >= PROT_LO) && (addr <= PROT_HI);
    assign elig = valid && !(we && prot && core_busy);
endmodule

module mmio_bus_arbiter #(
    parameter int         N_REQ    = 2,
    parameter int         READ_LAT = 1,
    parameter logic [7:0] PROT_LO  = 8'h10,
    parameter logic [7:0] PROT_HI  = 8'h42
) (
    input logic               clk,
    input logic               rst,
    mmio_bus_arbiter_if.slave bus
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(READ_LAT + 2);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] XFER = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    gnt;
    logic [PW-1:0]    gnt_q;
    logic [PW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic             we_q;
    logic [7:0]       addr_q;
    logic [7:0]       wdata_q;
    logic [7:0]       rdata_q;
    logic [N_REQ-1:0] elig;
    logic             found;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        mmio_arb_elig #(.PROT_LO(PROT_LO), .PROT_HI(PROT_HI)) u_elig (
            .valid     (bus.req_valid[i]),
            .we        (bus.req_we[i]),
            .addr      (bus.req_addr[i]),
            .core_busy (bus.core_busy),
            .elig      (elig[i])
        );
    end

    // First eligible port scanning from ptr upward, wrapping at N_REQ.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = PW'((int'(ptr) + k) % N_REQ);
            if (!found && elig[idx]) begin
                found = 1'b1;
                gnt   = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt_q   <= '0;
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    state   <= XFER;
                    gnt_q   <= gnt;
                    we_q    <= bus.req_we[gnt];
                    addr_q  <= bus.req_addr[gnt];
                    wdata_q <= bus.req_wdata[gnt];
                    cnt     <= bus.req_we[gnt] ? '0 : CW'(READ_LAT);
                    ptr     <= PW'((int'(gnt) + 1) % N_REQ);
                end
                // Read data is sampled on the edge closing the last bus cycle.
                XFER: if (cnt == '0) begin
                    state   <= RESP;
                    rdata_q <= we_q ? 8'h00 : bus.rdata;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Ready is masked during reset so nothing is reported accepted on a discarded edge.
    assign bus.req_ready = (state == IDLE && found && !rst) ? (N_REQ'(1) << gnt) : '0;
    assign bus.rsp_valid = (state == RESP) ? (N_REQ'(1) << gnt_q) : '0;
    assign bus.rsp_rdata = rdata_q;
    assign bus.cs        = (state == XFER);
    assign bus.rd        = (state == XFER) && !we_q;
    assign bus.wr        = (state == XFER) && we_q;
    assign bus.addr      = (state == XFER) ? addr_q : 8'h00;
    assign bus.wdata     = (state == XFER && we_q) ? wdata_q : 8'h00;
    assign bus.bus_busy  = (state != IDLE);
endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Directed bench for mmio_bus_arbiter: vector table of single transactions plus
// hand sequences for round-robin, busy hold-off, mid-transfer reset and READ_LAT=2.
module tb_mmio_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmio_bus_arbiter_if #(.N_REQ(2)) a();
    mmio_bus_arbiter_if #(.N_REQ(2)) b();

    mmio_bus_arbiter #(.N_REQ(2), .READ_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(a));
    mmio_bus_arbiter #(.N_REQ(2), .READ_LAT(2)) dut_b (.clk(clk), .rst(rst), .bus(b));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    // Register slave models: contents i^0x5A after reset; data only valid in the
    // cycle READ_LAT after cs&rd is first sampled, 0xEE otherwise.
    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];
    int rc_a = 0;
    int rc_b = 0;

    always @(posedge clk) begin
        if (rst) for (int i = 0; i < 256; i++) mem_a[i] <= 8'(i) ^ 8'h5A;
        else if (a.wr) mem_a[a.addr] <= a.wdata;
        rc_a <= a.rd ? rc_a + 1 : 0;
    end
    always @(posedge clk) begin
        if (rst) for (int i = 0; i < 256; i++) mem_b[i] <= 8'(i) ^ 8'h5A;
        else if (b.wr) mem_b[b.addr] <= b.wdata;
        rc_b <= b.rd ? rc_b + 1 : 0;
    end
    always_comb a.rdata = (a.rd && rc_a == 1) ? mem_a[a.addr] : 8'hEE;
    always_comb b.rdata = (b.rd && rc_b == 2) ? mem_b[b.addr] : 8'hEE;

    // Bus invariants checked every cycle on both instances.
    always @(negedge clk) begin
        chk("inv_a", {a.rd & a.wr, a.cs != (a.rd | a.wr), !$onehot0(a.rsp_valid | a.req_ready),
                      !a.cs && (a.addr != 8'h00 || a.wdata != 8'h00)}, 0);
        chk("inv_b", {b.rd & b.wr, b.cs != (b.rd | b.wr), !$onehot0(b.rsp_valid | b.req_ready),
                      !b.cs && (b.addr != 8'h00 || b.wdata != 8'h00)}, 0);
    end

    typedef struct {
        int         port;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        bit         busy;
        logic [7:0] exp_rd;
    } vec_t;

    // One full transaction on instance a (READ_LAT=1); call just after a posedge in IDLE.
    task automatic txn(input int p, input bit we, input logic [7:0] ad, input logic [7:0] wd,
                       input bit busy, input logic [7:0] exp_rd);
        int nx;
        nx = we ? 1 : 2;
        a.core_busy = busy;
        a.req_valid[p] = 1'b1;
        a.req_we[p]    = we;
        a.req_addr[p]  = ad;
        a.req_wdata[p] = wd;
        @(negedge clk);
        chk("ready", a.req_ready, 32'(1) << p);
        @(posedge clk); #1;
        a.req_valid[p] = 1'b0;
        a.req_addr[p]  = 8'hFF;
        a.req_wdata[p] = ~wd;
        for (int k = 0; k < nx; k++) begin
            @(negedge clk);
            chk("xfer_bus", {a.cs, a.rd, a.wr, a.addr, a.wdata},
                {1'b1, !we, we, ad, we ? wd : 8'h00});
            chk("xfer_rsp", a.rsp_valid, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("resp", {a.cs, a.bus_busy, a.rsp_valid, a.rsp_rdata},
            {1'b0, 1'b1, 2'(1 << p), exp_rd});
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle", {a.bus_busy, a.rsp_valid}, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vecs[10];
        int   n, last, cyc, got, seen;

        vecs[0] = '{0, 1'b1, 8'h10, 8'hA1, 1'b0, 8'h00};
        vecs[1] = '{0, 1'b0, 8'h10, 8'h00, 1'b0, 8'hA1};
        vecs[2] = '{1, 1'b1, 8'h42, 8'h5C, 1'b0, 8'h00};
        vecs[3] = '{1, 1'b0, 8'h42, 8'h00, 1'b0, 8'h5C};
        vecs[4] = '{0, 1'b0, 8'h0F, 8'h00, 1'b0, 8'h55};
        vecs[5] = '{1, 1'b1, 8'h01, 8'h77, 1'b1, 8'h00};
        vecs[6] = '{0, 1'b1, 8'h43, 8'h33, 1'b1, 8'h00};
        vecs[7] = '{0, 1'b0, 8'h01, 8'h00, 1'b0, 8'h77};
        vecs[8] = '{1, 1'b0, 8'h43, 8'h00, 1'b1, 8'h33};
        vecs[9] = '{1, 1'b1, 8'h0F, 8'hC3, 1'b1, 8'h00};

        a.req_valid = '0; a.req_we = '0; a.req_addr = '0; a.req_wdata = '0; a.core_busy = 1'b0;
        b.req_valid = '0; b.req_we = '0; b.req_addr = '0; b.req_wdata = '0; b.core_busy = 1'b0;

        // Reset state, with requests pending that must not be acknowledged.
        repeat (2) @(posedge clk);
        #1 a.req_valid = 2'b11;
        @(negedge clk);
        chk("reset_out", {a.cs, a.rd, a.wr, a.addr, a.wdata, a.bus_busy, a.rsp_valid,
                          a.rsp_rdata, a.req_ready}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        a.req_valid = '0;

        // READ_LAT=2 instance: response one cycle later than READ_LAT=1.
        b.req_valid[1] = 1'b1; b.req_addr[1] = 8'h30;
        @(negedge clk);
        chk("lat2_ready", b.req_ready, 2'b10);
        @(posedge clk); #1;
        b.req_valid[1] = 1'b0;
        cyc = 1;
        while (cyc < 12) begin
            @(negedge clk);
            if (b.rsp_valid != 0) break;
            @(posedge clk); #1;
            cyc++;
        end
        chk("lat2_cycles", cyc, 4);
        chk("lat2_data", {b.rsp_valid, b.rsp_rdata}, {2'b10, 8'h6A});
        @(posedge clk); #1;

        foreach (vecs[i])
            txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].busy, vecs[i].exp_rd);

        // Both ports streaming reads: grants alternate 0,1,0,1, one response every 4 cycles.
        a.core_busy = 1'b0; a.req_we = '0;
        a.req_addr[0] = 8'h30; a.req_addr[1] = 8'h38;
        a.req_valid = 2'b11;
        n = 0; last = -1; cyc = 0;
        while (n < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (a.rsp_valid != 0) begin
                chk("rr_owner", a.rsp_valid, 32'(1) << (n % 2));
                chk("rr_data", a.rsp_rdata, (n % 2) ? 8'h62 : 8'h6A);
                if (last >= 0) chk("rr_gap", cyc - last, 4);
                last = cyc;
                n++;
                if (n == 4) a.req_valid = '0;
            end
            @(posedge clk); #1;
        end
        chk("rr_count", n, 4);

        // Protected write held off by core_busy while the other port's read proceeds.
        a.core_busy = 1'b1;
        a.req_we = 2'b01;
        a.req_addr[0] = 8'h40; a.req_wdata[0] = 8'h99; a.req_addr[1] = 8'h41;
        a.req_valid = 2'b11;
        @(negedge clk);
        chk("busy_grant", a.req_ready, 2'b10);
        @(posedge clk); #1;
        a.req_valid[1] = 1'b0;
        got = 0; seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (a.rsp_valid[1]) begin
                got++;
                chk("busy_rd", a.rsp_rdata, 8'h1B);
            end
            if (a.req_ready[0]) seen++;
            @(posedge clk); #1;
        end
        chk("busy_rsp_cnt", got, 1);
        chk("held_off", seen, 0);
        a.core_busy = 1'b0;
        @(negedge clk);
        chk("release", a.req_ready, 2'b01);
        @(posedge clk); #1;
        a.req_valid[0] = 1'b0;
        a.core_busy = 1'b1;
        @(negedge clk);
        chk("busy_wr_bus", {a.cs, a.wr, a.addr, a.wdata}, {1'b1, 1'b1, 8'h40, 8'h99});
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy_wr_rsp", a.rsp_valid, 2'b01);
        @(posedge clk); #1;
        txn(0, 1'b0, 8'h40, 8'h00, 1'b0, 8'h99);

        // Reset during a read transfer: abort, no response, pointer back to 0.
        a.req_valid[0] = 1'b1; a.req_we[0] = 1'b0; a.req_addr[0] = 8'h20;
        @(negedge clk);
        chk("rst_pre_grant", a.req_ready, 2'b01);
        @(posedge clk); #1;
        a.req_valid[0] = 1'b0;
        @(negedge clk);
        chk("rst_pre_xfer", {a.cs, a.rd}, 2'b11);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_abort", {a.cs, a.rd, a.wr, a.bus_busy, a.rsp_valid}, 0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (a.rsp_valid != 0) seen++;
        end
        chk("rst_no_rsp", seen, 0);
        @(posedge clk); #1;
        a.req_we = '0; a.req_addr[1] = 8'h38;
        a.req_valid = 2'b11;
        @(negedge clk);
        chk("rst_ptr", a.req_ready, 2'b01);
        @(posedge clk); #1;
        a.req_valid = '0;
        repeat (5) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
